// File: rtl/mealy_scan_ctrl.sv
// ---------------------------------------------------------------------------
// mealy_scan_ctrl
//
// Word-level sequencer for a bit-serial overlapping Mealy sequence detector.
// Takes one parallel word over a valid/ready handshake and clears the
// detector for one cycle. It then shifts the word out MSB-first on o_x and
// samples the detector's same-cycle output at the edge that ends each bit
// cycle. When the word is finished it reports the number of detections
// (and optionally a per-bit hit mask) alongside a one-cycle o_done pulse.
//
// Handshake: a word is accepted on a rising edge where i_valid=1 and
// o_ready=1. o_ready is high only in IDLE. i_valid seen while o_ready=0 is
// ignored, and the producer holds i_valid/i_data until the accepting edge.
//
// Optional feature macro: SCAN_HIT_MASK_EN
//   defined   -> o_hit_mask port and mask registers exist
//   undefined -> only o_count is reported; timing is unchanged
//
// Parameters:
//   WIDTH  bits per scanned word (>= 2)
//   CNT_W  detection counter width, 2**CNT_W > WIDTH
//
// Ports:
//   i_clk           clock, rising edge
//   i_rst_b         asynchronous active-low reset
//   i_valid/i_data  word request / word to scan (bit WIDTH-1 first)
//   o_ready         controller can accept a word (IDLE)
//   o_x             serial bit to the detector
//   o_det_rst_b     active-low detector reset, low for the CLR cycle
//   i_seq_detected  detector output (Mealy, same cycle as o_x)
//   o_done          one-cycle result-valid pulse
//   o_count         detections in the last completed word
//   o_hit_mask      per-bit hit flags (SCAN_HIT_MASK_EN only)
//   o_dbg_state     current FSM state, for debug/checkers
// ---------------------------------------------------------------------------
module mealy_scan_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_b,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_ready,
  output logic             o_x,
  output logic             o_det_rst_b,
  input  logic             i_seq_detected,
  output logic             o_done,
  output logic [CNT_W-1:0] o_count,
`ifdef SCAN_HIT_MASK_EN
  output logic [WIDTH-1:0] o_hit_mask,
`endif
  output logic [1:0]       o_dbg_state
);

  localparam int IDX_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLR   = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   sh_q, sh_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;       // running count for the word in flight
  logic [CNT_W-1:0]   count_q, count_d;   // published result
  logic               ready_q, ready_d;
  logic               x_q, x_d;
  logic               det_rst_b_q, det_rst_b_d;
  logic               done_q, done_d;
`ifdef SCAN_HIT_MASK_EN
  logic [WIDTH-1:0]   macc_q, macc_d;     // running hit mask for the word in flight
  logic [WIDTH-1:0]   hit_mask_q, hit_mask_d;
`endif

  always_comb begin
    state_d  = state_q;
    sh_d     = sh_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    count_d  = count_q;
`ifdef SCAN_HIT_MASK_EN
    macc_d     = macc_q;
    hit_mask_d = hit_mask_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (i_valid) begin
          sh_d    = i_data;
          idx_d   = '0;
          cnt_d   = '0;
`ifdef SCAN_HIT_MASK_EN
          macc_d  = '0;
`endif
          state_d = ST_CLR;
        end
      end
      ST_CLR: begin
        // Detector is held in reset this cycle; its output is not sampled.
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        sh_d  = {sh_q[WIDTH-2:0], 1'b0};
        idx_d = idx_q + IDX_W'(1);
        cnt_d = cnt_q + CNT_W'(i_seq_detected);
`ifdef SCAN_HIT_MASK_EN
        // Shifting hits in from the LSB leaves the flag for bit index k
        // at position WIDTH-1-k once all WIDTH samples are taken.
        macc_d = {macc_q[WIDTH-2:0], i_seq_detected};
`endif
        if (idx_q == LAST_IDX) begin
          idx_d      = '0;
          count_d    = cnt_d;
`ifdef SCAN_HIT_MASK_EN
          hit_mask_d = macc_d;
`endif
          state_d    = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are registered: each reflects the state being entered.
    ready_d     = (state_d == ST_IDLE);
    x_d         = (state_d == ST_SHIFT) && sh_d[WIDTH-1];
    det_rst_b_d = (state_d != ST_CLR);
    done_d      = (state_d == ST_DONE);
  end

  always_ff @(posedge i_clk or negedge i_rst_b) begin
    if (!i_rst_b) begin
      state_q     <= ST_IDLE;
      sh_q        <= '0;
      idx_q       <= '0;
      cnt_q       <= '0;
      count_q     <= '0;
      ready_q     <= 1'b1;
      x_q         <= 1'b0;
      det_rst_b_q <= 1'b0;
      done_q      <= 1'b0;
`ifdef SCAN_HIT_MASK_EN
      macc_q      <= '0;
      hit_mask_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      sh_q        <= sh_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      count_q     <= count_d;
      ready_q     <= ready_d;
      x_q         <= x_d;
      det_rst_b_q <= det_rst_b_d;
      done_q      <= done_d;
`ifdef SCAN_HIT_MASK_EN
      macc_q      <= macc_d;
      hit_mask_q  <= hit_mask_d;
`endif
    end
  end

  assign o_ready     = ready_q;
  assign o_x         = x_q;
  assign o_det_rst_b = det_rst_b_q;
  assign o_done      = done_q;
  assign o_count     = count_q;
`ifdef SCAN_HIT_MASK_EN
  assign o_hit_mask  = hit_mask_q;
`endif
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_mealy_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mealy_scan_ctrl
//
// Directed + randomized bench for mealy_scan_ctrl (WIDTH=8, CNT_W=4).
// i_seq_detected comes either from a per-bit stub pattern or from a
// behavioural overlapping "101" detector. Expected counts/masks come from
// the stub pattern itself or from a scan of the word for "101" windows.
// Inputs are driven and outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_mealy_scan_ctrl;

  localparam int W  = 8;
  localparam int CW = 4;

  // ---------------- clock / reset / signals ----------------
  logic          i_clk = 1'b0;
  logic          i_rst_b;
  logic          i_valid;
  logic [W-1:0]  i_data;
  logic          o_ready;
  logic          o_x;
  logic          o_det_rst_b;
  logic          i_seq_detected;
  logic          o_done;
  logic [CW-1:0] o_count;
`ifdef SCAN_HIT_MASK_EN
  logic [W-1:0]  o_hit_mask;
`endif
  logic [1:0]    o_dbg_state;

  always #5 i_clk = ~i_clk;

  int cyc    = 0;
  int n_done = 0;
  always @(posedge i_clk) begin
    cyc <= cyc + 1;
    if (o_done === 1'b1) n_done <= n_done + 1;
  end

  mealy_scan_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
    .i_clk          (i_clk),
    .i_rst_b        (i_rst_b),
    .i_valid        (i_valid),
    .i_data         (i_data),
    .o_ready        (o_ready),
    .o_x            (o_x),
    .o_det_rst_b    (o_det_rst_b),
    .i_seq_detected (i_seq_detected),
    .o_done         (o_done),
    .o_count        (o_count),
`ifdef SCAN_HIT_MASK_EN
    .o_hit_mask     (o_hit_mask),
`endif
    .o_dbg_state    (o_dbg_state)
  );

  // ---------------- detector source ----------------
  logic mode_det;   // 1: behavioural detector, 0: stub
  logic stub_det;

  // Behavioural overlapping "101" detector: remembers the bits received
  // since its last reset and flags when the last two plus the current bit
  // spell 1,0,1.
  int         rx_n;
  logic [1:0] rx_last;
  always @(posedge i_clk or negedge o_det_rst_b) begin
    if (!o_det_rst_b) begin
      rx_n    <= 0;
      rx_last <= 2'b00;
    end else begin
      rx_n    <= (rx_n < 2) ? rx_n + 1 : 2;
      rx_last <= {rx_last[0], o_x};
    end
  end
  wire det_out = (rx_n >= 2) && (rx_last == 2'b10) && o_x;

  assign i_seq_detected = mode_det ? det_out : stub_det;

  // ---------------- reference model ----------------
  function automatic int ref_count(input logic [W-1:0] w);
    int c = 0;
    for (int p = W - 1; p >= 2; p--)
      if (w[p] && !w[p-1] && w[p-2]) c++;
    return c;
  endfunction

  function automatic logic [W-1:0] ref_mask(input logic [W-1:0] w);
    logic [W-1:0] m = '0;
    for (int p = W - 1; p >= 2; p--)
      if (w[p] && !w[p-1] && w[p-2]) m[p-2] = 1'b1;
    return m;
  endfunction

  // ---------------- checking ----------------
  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
      else begin
        bad++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic step();
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  int           prev_acc   = -1;
  int           last_count = 0;
  logic [W-1:0] last_mask  = '0;

  // Scans one word. Called at a falling edge with the DUT in IDLE.
  // pat bit W-1-b is the stub output in bit cycle b; stub_clr is the stub
  // output before the bits (accept and CLR cycles). busy_bit >= 0 pulses a
  // rejected request (8'h3C) in that bit cycle.
  task automatic run_word(input logic [W-1:0] w, input logic use_det,
                          input logic [W-1:0] pat, input logic stub_clr,
                          input logic hold_valid, input logic chk_sp,
                          input int busy_bit);
    int           exp_cnt;
    logic [W-1:0] exp_mask;
    exp_cnt  = use_det ? ref_count(w) : $countones(pat);
    exp_mask = use_det ? ref_mask(w) : pat;
    mode_det = use_det;
    stub_det = stub_clr;
    chk("ready_before_accept", 32'(o_ready), 32'd1);
    i_valid = 1'b1;
    i_data  = w;
    if (chk_sp) chk("accept_spacing", 32'(cyc - prev_acc), 32'd11);
    prev_acc = cyc;
    step();                                   // cycle k+1: CLR
    if (!hold_valid) i_valid = 1'b0;
    chk("clr_ready", 32'(o_ready), 32'd0);
    chk("clr_det_rst_b", 32'(o_det_rst_b), 32'd0);
    chk("clr_x", 32'(o_x), 32'd0);
    chk("count_hold_on_accept", 32'(o_count), 32'(last_count));
    step();                                   // cycle k+2: bit 0
    for (int b = 0; b < W; b++) begin
      chk($sformatf("x_bit%0d", b), 32'(o_x), 32'(w[W-1-b]));
      chk("shift_det_rst_b", 32'(o_det_rst_b), 32'd1);
      chk("shift_no_done", 32'(o_done), 32'd0);
      if (!use_det) stub_det = pat[W-1-b];
      if (b == busy_bit) begin
        i_valid = 1'b1;
        i_data  = 8'h3C;
      end else if (busy_bit >= 0 && b == busy_bit + 1) begin
        i_valid = 1'b0;
        i_data  = w;
      end
      step();
    end
    // cycle k+10: DONE
    stub_det = 1'b0;
    chk("done_pulse", 32'(o_done), 32'd1);
    chk("done_ready", 32'(o_ready), 32'd0);
    chk("count", 32'(o_count), 32'(exp_cnt));
`ifdef SCAN_HIT_MASK_EN
    chk("hit_mask", 32'(o_hit_mask), 32'(exp_mask));
`endif
    last_count = exp_cnt;
    last_mask  = exp_mask;
    step();                                   // cycle k+11: IDLE
    chk("done_one_cycle", 32'(o_done), 32'd0);
    chk("ready_return", 32'(o_ready), 32'd1);
    chk("count_hold", 32'(o_count), 32'(exp_cnt));
  endtask

  // ---------------- directed / random sequence ----------------
  initial begin
    int           snap;
    logic [W-1:0] w;
    i_rst_b  = 1'b1;
    i_valid  = 1'b0;
    i_data   = '0;
    mode_det = 1'b0;
    stub_det = 1'b0;
    #2 i_rst_b = 1'b0;
    repeat (2) step();

    // Reset / idle
    chk("rst_ready", 32'(o_ready), 32'd1);
    chk("rst_x", 32'(o_x), 32'd0);
    chk("rst_det_rst_b", 32'(o_det_rst_b), 32'd0);
    chk("rst_done", 32'(o_done), 32'd0);
    chk("rst_count", 32'(o_count), 32'd0);
`ifdef SCAN_HIT_MASK_EN
    chk("rst_mask", 32'(o_hit_mask), 32'd0);
`endif
    i_rst_b = 1'b1;
    step();
    chk("release_det_rst_b", 32'(o_det_rst_b), 32'd1);
    chk("release_ready", 32'(o_ready), 32'd1);
    repeat (4) begin
      step();
      chk("idle_no_done", 32'(o_done), 32'd0);
      chk("idle_count", 32'(o_count), 32'd0);
    end

    // Stub detector on 8'hA5, hits in bit cycles 2 and 5
    run_word(8'hA5, 1'b0, 8'b0010_0100, 1'b0, 1'b0, 1'b0, -1);

    // Random words with random stub patterns
    repeat (4) begin
      run_word(W'($urandom), 1'b0, W'($urandom), 1'($urandom_range(0, 1)),
               1'b0, 1'b0, -1);
      repeat ($urandom_range(0, 3)) step();
    end

    // Detector integration, back-to-back with i_valid held
    run_word(8'hFF, 1'b1, '0, 1'b0, 1'b1, 1'b0, -1);
    run_word(8'h00, 1'b1, '0, 1'b0, 1'b1, 1'b1, -1);
    run_word(8'hB6, 1'b1, '0, 1'b0, 1'b1, 1'b1, -1);
    i_valid = 1'b0;
    step();

    // Random words through the detector
    repeat (5) begin
      run_word(W'($urandom), 1'b1, '0, 1'b0, 1'b0, 1'b0, -1);
      repeat ($urandom_range(0, 2)) step();
    end

    // Busy request during SHIFT is ignored
    snap = n_done;
    run_word(W'($urandom), 1'b1, '0, 1'b0, 1'b0, 1'b0, 3);
    repeat (3) step();
    chk("busy_ready_idle", 32'(o_ready), 32'd1);
    chk("busy_one_done", 32'(n_done - snap), 32'd1);
    run_word(8'h81, 1'b1, '0, 1'b0, 1'b0, 1'b0, -1);

    // Stub held high throughout, including the CLR cycle
    run_word(W'($urandom), 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0, -1);

    // Mid-scan reset at bit 4
    w        = W'($urandom);
    mode_det = 1'b1;
    i_valid  = 1'b1;
    i_data   = w;
    step();                                   // CLR
    i_valid = 1'b0;
    repeat (5) step();                        // bit 4
    snap    = n_done;
    i_rst_b = 1'b0;
    #1;
    chk("midrst_ready", 32'(o_ready), 32'd1);
    chk("midrst_x", 32'(o_x), 32'd0);
    chk("midrst_det_rst_b", 32'(o_det_rst_b), 32'd0);
    chk("midrst_done", 32'(o_done), 32'd0);
    chk("midrst_count", 32'(o_count), 32'd0);
`ifdef SCAN_HIT_MASK_EN
    chk("midrst_mask", 32'(o_hit_mask), 32'd0);
`endif
    @(negedge i_clk);
    step();
    i_rst_b = 1'b1;
    repeat (8) step();
    chk("midrst_no_done", 32'(n_done - snap), 32'd0);
    chk("midrst_count_after", 32'(o_count), 32'd0);
    last_count = 0;
    last_mask  = '0;
    run_word(W'($urandom), 1'b1, '0, 1'b0, 1'b0, 1'b0, -1);
    run_word(8'hB5, 1'b1, '0, 1'b0, 1'b0, 1'b0, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mealy_scan_ctrl.md
# mealy_scan_ctrl

Word-level sequencer for the overlapping Mealy sequence detector. Accepts a parallel word over a valid/ready handshake and clears the detector. It then serialises the word MSB-first onto the detector's serial input, sampling the detector's output every bit cycle. It reports the detection count, and optionally per-bit hit positions, with a one-cycle done pulse. It sits between a word-oriented producer and a single bit-serial detector instance.

## Interface
- WIDTH, 8, bits per scanned word (≥ 2)
- CNT_W, 4, width of detection counter; must satisfy 2^CNT_W > WIDTH
- i_clk  input  1  clock, rising edge
- i_rst_b  input  1  asynchronous active-low reset
- i_valid  input  1  word request
- i_data  input  WIDTH  word to scan; bit WIDTH-1 is sent first
- o_ready  output  1  controller can accept a word
- o_x  output  1  serial bit to detector i_x
- o_det_rst_b  output  1  active-low reset to detector i_rst_b
- i_seq_detected  input  1  detector o_seq_detected (Mealy, same-cycle)
- o_done  output  1  one-cycle pulse: result valid
- o_count  output  CNT_W  detections in last word
- o_hit_mask  output  WIDTH  per-bit hit flags (only with SCAN_HIT_MASK_EN)

## Operation
- States: IDLE, CLR, SHIFT, DONE; all outputs registered.
- IDLE: o_ready=1, o_x=0, o_det_rst_b=1. On i_valid=1, load i_data into shift register, clear bit index/count/mask, go to CLR.
- CLR: o_det_rst_b=0 for exactly one cycle, o_x=0; i_seq_detected ignored; go to SHIFT.
- SHIFT: o_x = shift register MSB. At each edge, sample i_seq_detected. If 1, increment count and set mask bit WIDTH-1-idx. Then shift left and increment idx. After WIDTH samples go to DONE.
- DONE: o_done=1 for one cycle; go to IDLE.
- o_count and o_hit_mask update on the edge entering DONE. They hold until the next DONE; they are not cleared on accept.
- i_valid outside IDLE: ignored, no accept. Producer holds i_valid and i_data until the handshake.
- Detection at bit k means the detector asserted while bit k was on o_x. Overlapping detections are counted individually.
- Detector state never crosses word boundaries; CLR resets it per word.
- Count cannot overflow given the CNT_W constraint; no saturation logic.

## Timing
- Reset (async assert): state IDLE. o_ready=1, o_x=0, o_det_rst_b=0, o_done=0, o_count=0, o_hit_mask=0. Shift register and index are 0.
- First edge after reset release drives o_det_rst_b=1.
- Accept at edge k: CLR in cycle k+1. Bits occupy cycles k+2 … k+WIDTH+1. o_done is high in cycle k+WIDTH+2. o_ready returns high in cycle k+WIDTH+3.
- Throughput: one word per WIDTH+3 cycles with i_valid held continuously.
- i_seq_detected is sampled at the edge ending each bit cycle, the same edge on which the detector updates state.
- Reset mid-scan: partial count is discarded, outputs go to reset values, and no o_done is issued.

## Configuration
- SCAN_HIT_MASK_EN defined: o_hit_mask port and mask register exist, with behaviour as above.
- SCAN_HIT_MASK_EN undefined: o_hit_mask port and mask logic are removed, and only o_count is reported. Timing and all other behaviour are identical.

## Test plan
- Reset/idle: hold i_rst_b=0 then release, with i_valid=0. Required: o_ready=1, o_det_rst_b 0→1 after the first edge, o_done never asserts, o_count=0.
- Stub detector: accept i_data=8'hA5. Bench drives i_seq_detected=1 in bit cycles 2 and 5. Required:
  - o_x sequence 1,0,1,0,0,1,0,1;
  - o_det_rst_b low exactly in cycle k+1;
  - o_done in cycle k+10;
  - o_count=2, o_hit_mask=8'b0010_0100.
- Integration with the team detector instance: scan 8'hFF, 8'h00 and 8'hB6 back-to-back with i_valid held. Required:
  - each o_count equals the bench's overlapping-match reference model on that word alone;
  - accepts are spaced 11 cycles apart.
- Busy request: pulse i_valid with 8'h3C during SHIFT, then present 8'h81 in IDLE. Required: only 8'h81 is scanned; exactly one o_done.
- Saturation of bits: bench holds i_seq_detected=1 throughout. Required: o_count=8, o_hit_mask=8'hFF, and detections during CLR are not counted.
- Mid-scan reset: assert i_rst_b=0 at bit 4. Required: immediate reset values and no o_done. The next word is scanned with the correct count.
